// File: rtl/cover_pkg.sv
// Shared types and constants for the cover-point toggle collector.
package cover_pkg;

  // FIRST_HIT reports a point once until cleared; RISE reports every 0->1 edge.
  typedef enum logic {
    FIRST_HIT = 1'b0,
    RISE      = 1'b1
  } cover_mode_t;

  // Report FSM: EMPTY presents nothing, HOLD presents rpt_index until accepted.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } rpt_state_t;

  // Width of the global cover index carried on the report channel.
  localparam int COVER_IDX_W = 64;

endpackage

// File: rtl/cover_toggle_collector_if.sv
// Report channel: valid/ready handshake carrying a global cover index.
interface cover_toggle_collector_if;
  import cover_pkg::*;

  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [COVER_IDX_W-1:0] rpt_index;

  modport master (output rpt_valid, output rpt_index, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_index, output rpt_ready);

endinterface

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending cover point.
module cover_prio_enc #(
  parameter int WIDTH = 44,
  parameter int IDX_W = 6
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Collects per-point cover events into a sticky hit bitmap and a pending set,
// and drains pending points one per cycle over a valid/ready report channel.
//
// state | meaning
// EMPTY | no report presented, loads lowest pending bit when one exists
// HOLD  | rpt_index presented; on acceptance reload next pending or go EMPTY
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int          COVER_WIDTH = 44,
  parameter int          COVER_INDEX = 0,
  parameter int          COVER_TOTAL = 38253,
  parameter cover_mode_t COVER_MODE  = FIRST_HIT,
  localparam int         CNT_W       = $clog2(COVER_WIDTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COVER_WIDTH-1:0]   valid,
  input  logic                     enable,
  input  logic                     clear,
  cover_toggle_collector_if.master rpt,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     all_hit
);

  localparam int IDX_W = (COVER_WIDTH > 1) ? $clog2(COVER_WIDTH) : 1;

  if (COVER_WIDTH < 1 || COVER_WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: COVER_WIDTH must be in 1..1024");
  end
  if (COVER_INDEX + COVER_WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+COVER_WIDTH exceeds COVER_TOTAL");
  end

  logic [COVER_WIDTH-1:0] hit;
  logic [COVER_WIDTH-1:0] pending;
  logic [COVER_WIDTH-1:0] valid_q;
  logic [COVER_WIDTH-1:0] new_ev;
  logic [COVER_WIDTH-1:0] load_mask;
  logic [COVER_WIDTH-1:0] pending_nxt;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_any;
  logic                   load;
  logic [CNT_W-1:0]       pop;
  rpt_state_t             state;

  cover_prio_enc #(
    .WIDTH (COVER_WIDTH),
    .IDX_W (IDX_W)
  ) u_prio (
    .mask  (pending),
    .index (sel_idx),
    .any   (sel_any)
  );

  // New events, load decision and next pending set. A bit loaded this cycle
  // can be re-raised by an event in the same cycle; in FIRST_HIT the hit bit
  // is already set so it never is. In RISE an edge on an already pending bit
  // simply merges into it.
  always_comb begin
    if (COVER_MODE == RISE) begin
      new_ev = {COVER_WIDTH{enable}} & valid & ~valid_q;
    end else begin
      new_ev = {COVER_WIDTH{enable}} & valid & ~hit;
    end
    load        = sel_any & ~clear & ((state == EMPTY) | rpt.rpt_ready);
    load_mask   = load ? (COVER_WIDTH'(1) << sel_idx) : '0;
    pending_nxt = (pending & ~load_mask) | new_ev;
  end

  // Population count of the hit bitmap, registered below.
  always_comb begin
    pop = '0;
    for (int i = 0; i < COVER_WIDTH; i++) begin
      pop = pop + CNT_W'(hit[i]);
    end
  end

  // Previous-cycle valid for RISE edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid;
    end
  end

  // Sticky hit bitmap and pending set; clear wipes both and ignores valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit     <= '0;
      pending <= '0;
    end else if (clear) begin
      hit     <= '0;
      pending <= '0;
    end else begin
      hit     <= hit | ({COVER_WIDTH{enable}} & valid);
      pending <= pending_nxt;
    end
  end

  // Registered distinct-hit count, lagging the bitmap by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count <= '0;
    end else if (clear) begin
      hit_count <= '0;
    end else begin
      hit_count <= pop;
    end
  end

  assign all_hit = (hit_count == CNT_W'(COVER_WIDTH));

  // Report FSM with registered rpt_valid/rpt_index. An entry already held
  // when clear arrives stays presented until the consumer takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= EMPTY;
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_index <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            rpt.rpt_index <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(sel_idx);
            rpt.rpt_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (rpt.rpt_ready) begin
            if (load) begin
              rpt.rpt_index <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(sel_idx);
            end else begin
              rpt.rpt_valid <= 1'b0;
              state         <= EMPTY;
            end
          end
        end
        default: begin
          state         <= EMPTY;
          rpt.rpt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench: a FIRST_HIT instance (index base 100) and a RISE instance
// (index base 200) share clock, reset and stimulus.
module tb_cover_toggle_collector;
  import cover_pkg::*;

  localparam int W = 44;

  logic          clock;
  logic          reset;
  logic [W-1:0]  valid;
  logic          enable;
  logic          clear;
  logic          ready;
  logic [5:0]    hc_fh;
  logic [5:0]    hc_rs;
  logic          ah_fh;
  logic          ah_rs;

  cover_toggle_collector_if if_fh ();
  cover_toggle_collector_if if_rs ();

  assign if_fh.rpt_ready = ready;
  assign if_rs.rpt_ready = ready;

  cover_toggle_collector #(
    .COVER_WIDTH (W),
    .COVER_INDEX (100),
    .COVER_TOTAL (38253),
    .COVER_MODE  (FIRST_HIT)
  ) dut_fh (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .enable    (enable),
    .clear     (clear),
    .rpt       (if_fh.master),
    .hit_count (hc_fh),
    .all_hit   (ah_fh)
  );

  cover_toggle_collector #(
    .COVER_WIDTH (W),
    .COVER_INDEX (200),
    .COVER_TOTAL (38253),
    .COVER_MODE  (RISE)
  ) dut_rs (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .enable    (enable),
    .clear     (clear),
    .rpt       (if_rs.master),
    .hit_count (hc_rs),
    .all_hit   (ah_rs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accepted reports, captured at the negedge before the accepting posedge.
  logic [63:0] fh_q[$];
  logic [63:0] rs_q[$];
  always @(negedge clock) begin
    if (reset) begin
      if (if_fh.rpt_valid && if_fh.rpt_ready) fh_q.push_back(if_fh.rpt_index);
      if (if_rs.rpt_valid && if_rs.rpt_ready) rs_q.push_back(if_rs.rpt_index);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [W-1:0] valid;
    logic         en;
    logic         clr;
    logic         rdy;
    logic         e_rv;
    logic [63:0]  e_idx;
    logic [5:0]   e_hc;
    logic         e_ah;
  } vec_t;

  vec_t tbl[14];

  initial begin : main
    int bad;

    //             valid              en    clr   rdy   rv    idx     hc    ah
    tbl[0]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b0, 64'd0,   6'd0, 1'b0};
    tbl[1]  = '{44'h10000000088,   1'b1, 1'b0, 1'b1, 1'b0, 64'd0,   6'd0, 1'b0};
    tbl[2]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b1, 64'd103, 6'd3, 1'b0};
    tbl[3]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b1, 64'd107, 6'd3, 1'b0};
    tbl[4]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b1, 64'd140, 6'd3, 1'b0};
    tbl[5]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[6]  = '{44'h8,             1'b1, 1'b0, 1'b1, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[7]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[8]  = '{44'h400,           1'b0, 1'b0, 1'b1, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[9]  = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[10] = '{44'h1,             1'b1, 1'b0, 1'b0, 1'b0, 64'd140, 6'd3, 1'b0};
    tbl[11] = '{44'h0,             1'b1, 1'b0, 1'b0, 1'b1, 64'd100, 6'd4, 1'b0};
    tbl[12] = '{44'h0,             1'b1, 1'b0, 1'b0, 1'b1, 64'd100, 6'd4, 1'b0};
    tbl[13] = '{44'h0,             1'b1, 1'b0, 1'b1, 1'b0, 64'd100, 6'd4, 1'b0};

    reset  = 1'b0;
    valid  = '0;
    enable = 1'b1;
    clear  = 1'b0;
    ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rpt_valid", 64'(if_fh.rpt_valid), 64'd0);
    chk("reset_rpt_index", if_fh.rpt_index, 64'd0);
    chk("reset_hit_count", 64'(hc_fh), 64'd0);
    chk("reset_all_hit", 64'(ah_fh), 64'd0);
    reset = 1'b1;

    // Table: three hits in one cycle, repeat hit, enable gating, backpressure.
    for (int k = 0; k < 14; k++) begin
      valid  = tbl[k].valid;
      enable = tbl[k].en;
      clear  = tbl[k].clr;
      ready  = tbl[k].rdy;
      tick();
      chk($sformatf("tbl%0d_rpt_valid", k), 64'(if_fh.rpt_valid), 64'(tbl[k].e_rv));
      chk($sformatf("tbl%0d_rpt_index", k), if_fh.rpt_index, tbl[k].e_idx);
      chk($sformatf("tbl%0d_hit_count", k), 64'(hc_fh), 64'(tbl[k].e_hc));
      chk($sformatf("tbl%0d_all_hit", k), 64'(ah_fh), 64'(tbl[k].e_ah));
    end
    valid  = '0;
    enable = 1'b1;
    ready  = 1'b1;

    // FIRST_HIT: level held 10 cycles gives one report.
    fh_q.delete();
    valid = 44'h20;
    ticks(10);
    valid = '0;
    ticks(10);
    chk("first_hit_count", 64'(fh_q.size()), 64'd1);
    if (fh_q.size() >= 1) chk("first_hit_index", fh_q[0], 64'd105);

    // RISE: 0,1,0,1 on bit 2 gives two reports.
    rs_q.delete();
    valid = '0;          tick();
    valid = 44'h4;       tick();
    valid = '0;          tick();
    valid = 44'h4;       tick();
    valid = '0;
    ticks(8);
    chk("rise_count", 64'(rs_q.size()), 64'd2);
    if (rs_q.size() >= 2) begin
      chk("rise_index0", rs_q[0], 64'd202);
      chk("rise_index1", rs_q[1], 64'd202);
    end

    // RISE: repeated edges on a still-pending bit collapse into one report.
    rs_q.delete();
    ready = 1'b0;
    valid = 44'h2;  tick();
    valid = '0;     tick();
    for (int r = 0; r < 3; r++) begin
      valid = 44'h40; tick();
      valid = '0;     tick();
    end
    ready = 1'b1;
    ticks(8);
    chk("rise_drop_count", 64'(rs_q.size()), 64'd2);
    if (rs_q.size() >= 2) begin
      chk("rise_drop_index0", rs_q[0], 64'd201);
      chk("rise_drop_index1", rs_q[1], 64'd206);
    end

    // Long backpressure with four distinct hits.
    fh_q.delete();
    ready = 1'b0;
    valid = (44'h1 << 33) | (44'h1 << 20) | (44'h1 << 15) | (44'h1 << 9);
    tick();
    valid = '0;
    ticks(2);
    chk("bp_rpt_valid", 64'(if_fh.rpt_valid), 64'd1);
    chk("bp_rpt_index", if_fh.rpt_index, 64'd109);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if_fh.rpt_valid !== 1'b1 || if_fh.rpt_index !== 64'd109) bad++;
    end
    chk("bp_hold_unstable_cycles", 64'(bad), 64'd0);
    ready = 1'b1;
    ticks(8);
    chk("bp_count", 64'(fh_q.size()), 64'd4);
    if (fh_q.size() >= 4) begin
      chk("bp_index0", fh_q[0], 64'd109);
      chk("bp_index1", fh_q[1], 64'd115);
      chk("bp_index2", fh_q[2], 64'd120);
      chk("bp_index3", fh_q[3], 64'd133);
    end

    // All points hit, then clear while an entry is held.
    ready = 1'b0;
    valid = {W{1'b1}};
    tick();
    valid = '0;
    tick();
    chk("all_hit_count", 64'(hc_fh), 64'd44);
    chk("all_hit_flag", 64'(ah_fh), 64'd1);
    chk("all_hold_valid", 64'(if_fh.rpt_valid), 64'd1);
    chk("all_hold_index", if_fh.rpt_index, 64'd104);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_hit_count", 64'(hc_fh), 64'd0);
    chk("clear_all_hit", 64'(ah_fh), 64'd0);
    chk("clear_held_valid", 64'(if_fh.rpt_valid), 64'd1);
    chk("clear_held_index", if_fh.rpt_index, 64'd104);
    tick();
    chk("clear_hit_count_after", 64'(hc_fh), 64'd0);
    fh_q.delete();
    ready = 1'b1;
    ticks(10);
    chk("clear_drain_count", 64'(fh_q.size()), 64'd1);
    if (fh_q.size() >= 1) chk("clear_drain_index", fh_q[0], 64'd104);
    chk("clear_all_hit_end", 64'(ah_fh), 64'd0);

    // Reset with entries pending discards them.
    ready = 1'b0;
    valid = (44'h1 << 11) | (44'h1 << 12) | (44'h1 << 13);
    tick();
    valid = '0;
    ticks(2);
    chk("pre_reset_index", if_fh.rpt_index, 64'd111);
    reset = 1'b0;
    #1;
    chk("mid_reset_rpt_valid", 64'(if_fh.rpt_valid), 64'd0);
    chk("mid_reset_rpt_index", if_fh.rpt_index, 64'd0);
    chk("mid_reset_hit_count", 64'(hc_fh), 64'd0);
    chk("mid_reset_rs_hit_count", 64'(hc_rs), 64'd0);
    chk("mid_reset_rs_all_hit", 64'(ah_rs), 64'd0);
    ticks(2);
    reset = 1'b1;
    fh_q.delete();
    rs_q.delete();
    ready = 1'b1;
    ticks(10);
    chk("post_reset_fh_reports", 64'(fh_q.size()), 64'd0);
    chk("post_reset_rs_reports", 64'(rs_q.size()), 64'd0);
    chk("post_reset_rpt_valid", 64'(if_fh.rpt_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
